// File: rtl/sha256_digest_reader.sv
`default_nettype none
// ============================================================================
// Module  : sha256_digest_reader
// Purpose : Captures the eight final SHA-256 chaining words (H0..H7) from the
//           hash core accumulators on a single-cycle `done` pulse, then
//           streams them H0 first, one word per clock, over valid/ready.
//           A `done` that arrives while a digest is still streaming is
//           dropped and flagged on the sticky `overrun` output. The one
//           exception is a `done` on the final handshake cycle, which is
//           accepted with no bubble between the two digests.
// Ports   : clk       - rising-edge clock, shared with the hash core
//           rst       - asynchronous active-high reset
//           done      - pulse: h_in holds the final digest this cycle
//           h_in      - WORDS*DW digest, H0 in the most significant word
//           out_data  - current digest word (registered)
//           out_valid - out_data is valid
//           out_ready - consumer accepts out_data this cycle
//           out_last  - current word is H7 (registered)
//           busy      - a digest is held and not fully transferred
//           overrun   - sticky: a done was dropped while busy
// Config  : SHA256_DIGEST_BYTESWAP_EN - when defined, each word is
//           byte-reversed at capture (little-endian presentation).
// Rev     : 1.0 - initial release
// ============================================================================
module sha256_digest_reader #(
  parameter int WORDS = 8,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done,
  input  logic [WORDS*DW-1:0]   h_in,
  output logic [DW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overrun
);

  localparam int            IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n, idx_inc;
  logic [DW-1:0] hbuf [WORDS];
  logic [DW-1:0] data_n;
  logic          last_n, overrun_n;
  logic          handshake, at_last, capture;

  // Word presentation applied once, at capture time.
  function automatic logic [DW-1:0] present(input logic [DW-1:0] w);
    logic [DW-1:0] r;
`ifdef SHA256_DIGEST_BYTESWAP_EN
    for (int b = 0; b < DW / 8; b++) begin
      r[b*8 +: 8] = w[DW-8-b*8 +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign handshake = (state == SEND) && out_ready;
  assign at_last   = (idx == LAST_IDX);
  assign idx_inc   = idx + 1'b1;

  // A new digest is taken when idle, or when the last word leaves on the
  // same edge, so back-to-back digests stream without a gap.
  assign capture   = done && ((state == IDLE) || (handshake && at_last));

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    data_n    = out_data;
    overrun_n = overrun || (done && (state == SEND) && !(handshake && at_last));
    if (capture) begin
      state_n = SEND;
      idx_n   = '0;
      data_n  = present(h_in[(WORDS-1)*DW +: DW]);
    end else if (handshake) begin
      if (at_last) begin
        state_n = IDLE;
        idx_n   = '0;
        data_n  = '0;
      end else begin
        idx_n  = idx_inc;
        data_n = hbuf[idx_inc];
      end
    end
    // out_data/out_last are preloaded here so the outputs are pure flops.
    last_n = (state_n == SEND) && (idx_n == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      overrun  <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        hbuf[k] <= '0;
      end
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      out_data <= data_n;
      out_last <= last_n;
      overrun  <= overrun_n;
      if (capture) begin
        for (int k = 0; k < WORDS; k++) begin
          hbuf[k] <= present(h_in[(WORDS-1-k)*DW +: DW]);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha256_digest_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha256_digest_reader
// Purpose : Scoreboard bench for sha256_digest_reader. Stimulus pushes the
//           expected word stream when it pulses done; a negedge monitor pops
//           and compares on every accepted word.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_sha256_digest_reader;

  localparam logic [255:0] DIG_ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] DIG_B   = {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
                                      32'h00000001, 32'h80000000, 32'hdeadbeef, 32'hcafef00d};
  localparam logic [255:0] DIG_ONE = {8{32'h11111111}};
`ifdef SHA256_DIGEST_BYTESWAP_EN
  localparam logic [31:0] EXP_FIRST = 32'hbf1678ba;
  localparam logic [31:0] EXP_LAST  = 32'had1500f2;
  localparam logic [31:0] EXP_IDX3  = 32'h2322ae5d;
  localparam logic [31:0] EXP_B0    = 32'h67452301;
`else
  localparam logic [31:0] EXP_FIRST = 32'hba7816bf;
  localparam logic [31:0] EXP_LAST  = 32'hf20015ad;
  localparam logic [31:0] EXP_IDX3  = 32'h5dae2223;
  localparam logic [31:0] EXP_B0    = 32'h01234567;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done = 1'b0;
  logic         out_ready = 1'b0;
  logic [255:0] h_in = '0;
  logic [31:0]  out_data;
  logic         out_valid, out_last, busy, overrun;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0;
  int   checks = 0;
  int   hs = 0;

  always #5 clk = ~clk;

  sha256_digest_reader #(.WORDS(8), .DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .h_in      (h_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
  );

  function automatic logic [31:0] pres(input logic [31:0] w);
`ifdef SHA256_DIGEST_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse done with digest d across one edge; optionally record expectations.
  task automatic send_done(input logic [255:0] d, input bit push);
    exp_t e;
    if (push) begin
      for (int k = 0; k < 8; k++) begin
        e.d = pres(d[255-32*k -: 32]);
        e.l = (k == 7);
        sbq.push_back(e);
      end
    end
    h_in = d;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    chk1({name, "_idle"}, busy, 1'b0);
    chk({name, "_drained"}, 32'(sbq.size()), 32'd0);
  endtask

  // Monitor: every accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      hs++;
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_word: got %h expected none", out_data);
      end else begin
        e = sbq.pop_front();
        chk("word_data", out_data, e.d);
        chk1("word_last", out_last, e.l);
      end
    end
  end

  initial begin
    int base;
    int drops;

    // Reset state
    #12;
    chk1("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk1("rst_last", out_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Basic "abc" digest at full throughput
    out_ready = 1'b1;
    base = hs;
    send_done(DIG_ABC, 1'b1);
    chk1("abc_first_valid", out_valid, 1'b1);
    chk("abc_first_data", out_data, EXP_FIRST);
    chk1("abc_first_last", out_last, 1'b0);
    repeat (7) tick();
    chk1("abc_last_flag", out_last, 1'b1);
    chk("abc_last_data", out_data, EXP_LAST);
    tick();
    chk1("abc_valid_fall", out_valid, 1'b0);
    wait_idle("abc");
    chk("abc_count", 32'(hs - base), 32'd8);

    // Backpressure for 5 cycles at idx 3
    tick();
    base = hs;
    send_done(DIG_ABC, 1'b1);
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk1("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, EXP_IDX3);
    end
    out_ready = 1'b1;
    wait_idle("bp");
    chk("bp_count", 32'(hs - base), 32'd8);

    // Back-to-back: digest B lands on A's final handshake
    tick();
    base = hs;
    send_done(DIG_ABC, 1'b1);
    repeat (7) tick();
    send_done(DIG_B, 1'b1);
    chk1("b2b_valid", out_valid, 1'b1);
    chk("b2b_first", out_data, EXP_B0);
    chk1("b2b_overrun", overrun, 1'b0);
    drops = 0;
    for (int i = 0; i < 7; i++) begin
      if (!out_valid) drops++;
      tick();
    end
    chk("b2b_drops", 32'(drops), 32'd0);
    wait_idle("b2b");
    chk("b2b_count", 32'(hs - base), 32'd16);
    chk1("b2b_overrun_end", overrun, 1'b0);

    // Overrun: second done at idx 2 is dropped
    tick();
    base = hs;
    send_done(DIG_ABC, 1'b1);
    repeat (2) tick();
    send_done(DIG_ONE, 1'b0);
    chk1("ovr_set", overrun, 1'b1);
    wait_idle("ovr");
    chk("ovr_count", 32'(hs - base), 32'd8);
    tick();
    chk1("ovr_sticky", overrun, 1'b1);

    // Asynchronous reset at idx 5
    send_done(DIG_ABC, 1'b1);
    repeat (5) tick();
    #2;
    rst = 1'b1;
    sbq.delete();
    #1;
    chk1("arst_valid", out_valid, 1'b0);
    chk("arst_data", out_data, 32'h0);
    chk1("arst_last", out_last, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_overrun", overrun, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk1("post_rst_idle", busy, 1'b0);
    base = hs;
    send_done(DIG_ABC, 1'b1);
    chk("restart_first", out_data, EXP_FIRST);
    wait_idle("restart");
    chk("restart_count", 32'(hs - base), 32'd8);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
